// File: rtl/ccff_chain_loader.sv
// Writer end of a ccff_head -> ccff_tail configuration chain: serializes bitstream words onto
// the chain and returns the bits shifted out of ccff_tail as readback words.
//
// state | meaning
// IDLE  | waiting for start; bit_count holds the last load's length
// SHIFT | accepting words and stepping bits onto ccff_head
// FLUSH | all bits stepped; waiting for the last tail sample and its rd handshake
// DONE  | one-cycle completion pulse
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int BC_W  = $clog2(WORD_W + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
  state_t state, next_state;

  logic [WORD_W-1:0] wbuf, wbuf_load, rb_buf, rb_word;
  logic [BC_W-1:0]   wbuf_cnt, load_cnt;
  logic [IDX_W-1:0]  rb_idx;
  logic [CNT_W-1:0]  remaining;
  logic              rd_last, launch, accept, step, word_closing, final_sample;

  assign launch       = (state == IDLE) && start;
  assign remaining    = LEN_C - bit_count;
  assign accept       = wr_valid && wr_ready;
  // A tail sample is taken on every edge where the chain is enabled.
  assign word_closing = chain_clk_en && (rb_idx == LAST_IDX);
  assign final_sample = chain_clk_en && (bit_count == LEN_C);
  // Hold off a step whose sample would land on a readback word that cannot be emitted yet.
  assign step         = (state == SHIFT) && (wbuf_cnt != '0) && !rd_valid && !word_closing;
  assign rb_word      = rb_buf | (WORD_W'(ccff_tail) << rb_idx);

  always_comb begin
    load_cnt  = BC_W'(WORD_W);
    wbuf_load = '0;
    if (32'(remaining) < WORD_W) load_cnt = BC_W'(remaining);
    for (int i = 0; i < WORD_W; i++) begin
      if (i < 32'(load_cnt)) wbuf_load[i] = wr_data[i];
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    wr_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = SHIFT;
      end
      SHIFT: begin
        busy     = 1'b1;
        wr_ready = (wbuf_cnt == '0) && (bit_count != LEN_C);
        if (bit_count == LEN_C) next_state = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (rd_valid && rd_ready && rd_last) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      ccff_head    <= 1'b0;
      chain_clk_en <= 1'b0;
      bit_count    <= '0;
      wbuf         <= '0;
      wbuf_cnt     <= '0;
      rb_buf       <= '0;
      rb_idx       <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
    end else begin
      chain_clk_en <= step;
      if (step) begin
        ccff_head <= wbuf[0];
        wbuf      <= wbuf >> 1;
        wbuf_cnt  <= wbuf_cnt - BC_W'(1);
        bit_count <= bit_count + CNT_W'(1);
      end else if (accept) begin
        wbuf     <= wbuf_load;
        wbuf_cnt <= load_cnt;
      end

      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      if (chain_clk_en) begin
        if (word_closing || final_sample) begin
          rd_data  <= rb_word;
          rd_valid <= 1'b1;
          rd_last  <= final_sample;
          rb_buf   <= '0;
          rb_idx   <= '0;
        end else begin
          rb_buf <= rb_word;
          rb_idx <= rb_idx + IDX_W'(1);
        end
      end

      if (launch) begin
        bit_count <= '0;
        wbuf      <= '0;
        wbuf_cnt  <= '0;
        rb_buf    <= '0;
        rb_idx    <= '0;
        rd_last   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: a 24-bit and a 10-bit chain instance, each driving plain shift-register chain flops.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       p_reset = 1'b0;
  logic       sel = 1'b0;
  logic       start = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       a_busy, a_done, a_wr_ready, a_rd_valid, a_head, a_en;
  logic [7:0] a_rd_data;
  logic [4:0] a_cnt;
  logic       b_busy, b_done, b_wr_ready, b_rd_valid, b_head, b_en;
  logic [7:0] b_rd_data;
  logic [3:0] b_cnt;

  logic [23:0] ch_a = '0;
  logic [9:0]  ch_b = '0;

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) u_a (
    .prog_clk(clk), .pReset(p_reset), .start(start && !sel), .busy(a_busy), .done(a_done),
    .wr_data(wr_data), .wr_valid(wr_valid && !sel), .wr_ready(a_wr_ready),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_ready(rd_ready && !sel),
    .ccff_head(a_head), .chain_clk_en(a_en), .ccff_tail(ch_a[23]), .bit_count(a_cnt));

  ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) u_b (
    .prog_clk(clk), .pReset(p_reset), .start(start && sel), .busy(b_busy), .done(b_done),
    .wr_data(wr_data), .wr_valid(wr_valid && sel), .wr_ready(b_wr_ready),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(rd_ready && sel),
    .ccff_head(b_head), .chain_clk_en(b_en), .ccff_tail(ch_b[9]), .bit_count(b_cnt));

  always @(posedge clk) if (a_en) ch_a <= {ch_a[22:0], a_head};
  always @(posedge clk) if (b_en) ch_b <= {ch_b[8:0], b_head};

  logic busy, done, wr_ready, rd_valid, en, head;
  logic [7:0]  rd_data;
  logic [4:0]  cnt;
  logic [23:0] chain_now;
  assign busy      = sel ? b_busy : a_busy;
  assign done      = sel ? b_done : a_done;
  assign wr_ready  = sel ? b_wr_ready : a_wr_ready;
  assign rd_valid  = sel ? b_rd_valid : a_rd_valid;
  assign en        = sel ? b_en : a_en;
  assign head      = sel ? b_head : a_head;
  assign rd_data   = sel ? b_rd_data : a_rd_data;
  assign cnt       = sel ? {1'b0, b_cnt} : a_cnt;
  assign chain_now = sel ? {14'd0, ch_b} : ch_a;

  int   en_edges = 0, inv_viol = 0;
  logic wr_ready_d = 1'b0;
  always @(posedge clk) if (en) en_edges <= en_edges + 1;
  // An empty word buffer in SHIFT must never be followed by an enabled chain edge.
  always @(negedge clk) begin
    wr_ready_d <= wr_ready;
    if (wr_ready_d && en) inv_viol <= inv_viol + 1;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a load returns the previous load's bitstream in order; bit i of words is stream bit i.
  logic [23:0] prev_s [2];
  bit          model_ok [2];
  logic [23:0] cur_words, cur_exp;

  typedef struct packed {
    logic        sel;
    logic [23:0] words;
    logic [7:0]  gap;
    logic [7:0]  stall;
    logic [23:0] exp_rd;
  } vec_t;
  vec_t tbl [6];

  task automatic run_load(input int gap, input int stall, input bit use_tbl, input bit poke);
    int len, nw, e0, v0, idx;
    bit chk_rd;
    logic [23:0] exp_rd, exp_chain;
    idx = sel ? 1 : 0;
    len = sel ? 10 : 24;
    nw  = (len + 7) / 8;
    chk_rd = use_tbl || model_ok[idx];
    exp_rd = '0;
    for (int i = 0; i < len; i++) exp_rd[i] = prev_s[idx][i];
    if (use_tbl) exp_rd = cur_exp;
    exp_chain = '0;
    for (int i = 0; i < len; i++) exp_chain[len-1-i] = cur_words[i];
    e0 = en_edges;
    v0 = inv_viol;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    fork
      begin
        for (int i = 0; i < nw; i++) begin
          int g, t;
          g = (gap < 0) ? int'($urandom_range(0, 6)) : gap;
          repeat (g) @(negedge clk);
          wr_data = cur_words[i*8 +: 8];
          wr_valid = 1'b1;
          t = 0;
          while (!wr_ready && t < 300) begin @(negedge clk); t++; end
          if (t >= 300) begin
            n_checks++; n_fail++;
            $display("FAIL wr_handshake: wr_ready not seen for word %0d within 300 cycles", i);
          end
          @(negedge clk);
          wr_valid = 1'b0;
          wr_data = 8'($urandom);
        end
      end
      begin
        for (int k = 0; k < nw; k++) begin
          int t, bad;
          t = 0;
          while (!rd_valid && t < 2000) begin @(negedge clk); t++; end
          if (t >= 2000) begin
            n_checks++; n_fail++;
            $display("FAIL rd_handshake: rd_valid not seen for word %0d within 2000 cycles", k);
          end
          if (k == 0 && stall > 0) begin
            bad = 0;
            repeat (stall) begin
              @(negedge clk);
              if (en || cnt > 5'd9) bad++;
            end
            check("stall_frozen", bad, 0);
            check("stall_rd_held", rd_valid, 1);
          end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
          end
          if (chk_rd) check("rd_word", rd_data, exp_rd[k*8 +: 8]);
          rd_ready = 1'b1;
          @(negedge clk);
          rd_ready = 1'b0;
          if (k == nw - 1) begin
            check("done_pulse", {done, busy}, 2'b10);
            @(negedge clk);
            check("done_width", done, 0);
          end
        end
      end
      begin
        if (poke) begin
          repeat (6) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join

    check("enabled_edges", en_edges - e0, len);
    check("gap_no_shift", inv_viol - v0, 0);
    check("chain_contents", chain_now, exp_chain);
    check("bit_count_hold", cnt, len);
    prev_s[idx]   = cur_words;
    model_ok[idx] = 1'b1;
  endtask

  task automatic reset_mid_load();
    int t;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    wr_data = 8'($urandom);
    t = 0;
    while (cnt != 5'd13 && t < 500) begin
      @(negedge clk);
      wr_data = 8'($urandom);
      t++;
    end
    if (t >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL reach_13: bit_count stuck at %0d", cnt);
    end
    #2 p_reset = 1'b0;
    #1 check("async_reset_outputs", {busy, done, wr_ready, rd_valid, head, en, rd_data, cnt}, 0);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    p_reset = 1'b1;
    model_ok[0] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 24'h0F3CA5, 8'd0, 8'd0,  24'h000000};
    tbl[1] = '{1'b0, 24'h8100FF, 8'd0, 8'd0,  24'h0F3CA5};
    tbl[2] = '{1'b0, 24'h563412, 8'd5, 8'd0,  24'h8100FF};
    tbl[3] = '{1'b0, 24'hDEBC9A, 8'd0, 8'd20, 24'h563412};
    tbl[4] = '{1'b1, 24'h00FEFF, 8'd0, 8'd0,  24'h000000};
    tbl[5] = '{1'b1, 24'h000300, 8'd0, 8'd0,  24'h0002FF};
    prev_s[0] = '0; prev_s[1] = '0;
    model_ok[0] = 1'b1; model_ok[1] = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_state_a", {a_busy, a_done, a_wr_ready, a_rd_valid, a_head, a_en, a_rd_data, a_cnt}, 0);
    check("reset_state_b", {b_busy, b_done, b_wr_ready, b_rd_valid, b_head, b_en, b_rd_data, b_cnt}, 0);
    p_reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      sel       = tbl[i].sel;
      cur_words = tbl[i].words;
      cur_exp   = tbl[i].exp_rd;
      run_load(int'(tbl[i].gap), int'(tbl[i].stall), 1'b1, 1'b0);
    end

    for (int r = 0; r < 8; r++) begin
      sel       = 1'(r % 2);
      cur_words = 24'($urandom);
      run_load(-1, ($urandom_range(0, 3) == 0) ? 12 : 0, 1'b0, 1'b0);
    end

    sel = 1'b0;
    reset_mid_load();
    cur_words = 24'($urandom);
    run_load(-1, 0, 1'b0, 1'b1);
    cur_words = 24'($urandom);
    run_load(-1, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
